// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signal bundle for the UART TX arbiter.
// master: requesters plus UART transmitter, slave: the arbiter.
interface uart_tx_arbiter_if;
   logic [3:0]  req_i;
   logic [3:0]  start_i;
   logic [31:0] data_i;
   logic        eot_i;
   logic [3:0]  gnt_o;
   logic [3:0]  eot_o;
   logic        err_o;
   logic        sttx_o;
   logic [7:0]  data_o;

   modport master (
      output req_i, start_i, data_i, eot_i,
      input  gnt_o, eot_o, err_o, sttx_o, data_o
   );

   modport slave (
      input  req_i, start_i, data_i, eot_i,
      output gnt_o, eot_o, err_o, sttx_o, data_o
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among 4 requesters; all outputs registered (1-cycle latency).
// Owner is held until it drops req_i in GRANT; a byte in flight waits for eot_i or TMO_CYCLES timeout.
module uart_tx_arbiter #(
   parameter logic [15:0] TMO_CYCLES = 16'd50000
) (
   input logic               clk_i,
   input logic               rst_i,
   uart_tx_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY} state_t;

   state_t      state_q, state_d;
   logic [3:0]  gnt_q, gnt_d;
   logic [3:0]  eot_q, eot_d;
   logic        err_q, err_d;
   logic        sttx_q, sttx_d;
   logic [7:0]  data_q, data_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  last_q, last_d;

   logic [1:0]  pick;
   logic [1:0]  cand;
   logic        found;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      eot_d   = 4'b0000;
      err_d   = 1'b0;
      sttx_d  = 1'b0;
      data_d  = data_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      pick    = last_q;
      cand    = 2'd0;
      found   = 1'b0;

      // Search starts one past the previous owner so every requester gets a turn.
      for (int i = 1; i <= 4; i++) begin
         cand = last_q + 2'(i);
         if (!found && bus.req_i[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (found) begin
               gnt_d   = 4'b0001 << pick;
               last_d  = pick;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (bus.start_i[last_q]) begin
               data_d  = bus.data_i[{last_q, 3'b000} +: 8];
               sttx_d  = 1'b1;
               cnt_d   = 16'd0;
               state_d = S_BUSY;
            end else if (!bus.req_i[last_q]) begin
               gnt_d   = 4'b0000;
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + 16'd1;
            // cnt_q == 0 marks the sttx_o cycle, where eot_i cannot belong to this byte.
            if (bus.eot_i && (cnt_q != 16'd0)) begin
               eot_d   = gnt_q;
               state_d = S_GRANT;
            end else if (cnt_q == TMO_CYCLES - 16'd1) begin
               eot_d   = gnt_q;
               err_d   = 1'b1;
               state_d = S_GRANT;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         gnt_q   <= 4'b0000;
         eot_q   <= 4'b0000;
         err_q   <= 1'b0;
         sttx_q  <= 1'b0;
         data_q  <= 8'h00;
         cnt_q   <= 16'd0;
         last_q  <= 2'd3;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         eot_q   <= eot_d;
         err_q   <= err_d;
         sttx_q  <= sttx_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign bus.gnt_o  = gnt_q;
   assign bus.eot_o  = eot_q;
   assign bus.err_o  = err_q;
   assign bus.sttx_o = sttx_q;
   assign bus.data_o = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a default-timeout instance and a TMO_CYCLES=8 instance.
module tb_uart_tx_arbiter;

   logic clk;
   logic rst;
   int   total;
   int   passed;

   uart_tx_arbiter_if bus ();
   uart_tx_arbiter_if bus_t ();

   uart_tx_arbiter dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   uart_tx_arbiter #(.TMO_CYCLES(16'd8)) dut_t (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Owner n sends byte b; eot_i is sampled dly edges after the start edge (dly >= 2).
   task automatic send_byte(input int n, input logic [7:0] b, input int dly);
      logic [3:0] oh;
      oh = 4'b0001 << n;
      bus.data_i = 32'hA5A5_A5A5;
      bus.data_i[8*n +: 8] = b;
      bus.start_i = oh;
      tick();
      chk("sttx_pulse", {31'd0, bus.sttx_o}, 32'd1);
      chk("data_latch", {24'd0, bus.data_o}, {24'd0, b});
      bus.start_i = 4'b0000;
      repeat (dly - 1) tick();
      bus.eot_i = 1'b1;
      tick();
      chk("eot_pulse", {28'd0, bus.eot_o}, {28'd0, oh});
      chk("err_quiet", {31'd0, bus.err_o}, 32'd0);
   endtask

   initial begin
      total  = 0;
      passed = 0;
      rst = 1'b1;
      bus.req_i = 4'b0000;   bus.start_i = 4'b0000;   bus.data_i = 32'd0;   bus.eot_i = 1'b0;
      bus_t.req_i = 4'b0000; bus_t.start_i = 4'b0000; bus_t.data_i = 32'd0; bus_t.eot_i = 1'b0;
      tick();
      tick();
      chk("rst_gnt", {28'd0, bus.gnt_o}, 32'd0);
      chk("rst_eot", {28'd0, bus.eot_o}, 32'd0);
      chk("rst_err", {31'd0, bus.err_o}, 32'd0);
      chk("rst_sttx", {31'd0, bus.sttx_o}, 32'd0);
      chk("rst_data", {24'd0, bus.data_o}, 32'd0);
      rst = 1'b0;

      // Single owner, eot_i 10 cycles after start.
      bus.req_i = 4'b0001;
      tick();
      chk("single_gnt", {28'd0, bus.gnt_o}, 32'h1);
      send_byte(0, 8'h79, 10);
      bus.eot_i = 1'b0;
      tick();
      chk("single_eot_one_cycle", {28'd0, bus.eot_o}, 32'h0);
      chk("single_back_grant", {28'd0, bus.gnt_o}, 32'h1);
      chk("single_sttx_once", {31'd0, bus.sttx_o}, 32'd0);
      chk("single_data_hold", {24'd0, bus.data_o}, 32'h79);
      bus.req_i = 4'b0000;
      tick();
      chk("single_release", {28'd0, bus.gnt_o}, 32'h0);

      // Round robin with all four requesting: order 0,1,2,3,0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req_i = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr_gnt", {28'd0, bus.gnt_o}, 32'h1 << (k % 4));
         send_byte(k % 4, 8'h10 + 8'(k), 2);
         bus.eot_i = 1'b0;
         bus.req_i = 4'b1111 & ~(4'b0001 << (k % 4));
         tick();
         chk("rr_release", {28'd0, bus.gnt_o}, 32'h0);
         bus.req_i = 4'b1111;
      end

      // Four-byte message from owner 2 while requester 0 also waits.
      bus.req_i = 4'b0101;
      tick();
      chk("msg_gnt", {28'd0, bus.gnt_o}, 32'h4);
      send_byte(2, 8'h79, 3); bus.eot_i = 1'b0; tick(); chk("msg_hold1", {28'd0, bus.gnt_o}, 32'h4);
      send_byte(2, 8'h6F, 3); bus.eot_i = 1'b0; tick(); chk("msg_hold2", {28'd0, bus.gnt_o}, 32'h4);
      send_byte(2, 8'h79, 3); bus.eot_i = 1'b0; tick(); chk("msg_hold3", {28'd0, bus.gnt_o}, 32'h4);
      send_byte(2, 8'h65, 3); bus.eot_i = 1'b0; tick(); chk("msg_hold4", {28'd0, bus.gnt_o}, 32'h4);
      bus.req_i = 4'b0001;
      tick();
      chk("msg_release", {28'd0, bus.gnt_o}, 32'h0);
      tick();
      chk("msg_next_owner0", {28'd0, bus.gnt_o}, 32'h1);
      chk("msg_data_kept", {24'd0, bus.data_o}, 32'h65);

      // Ignored starts: non-owners in GRANT, owner in BUSY; eot_i in GRANT.
      bus.data_i = 32'h4433_2211;
      bus.start_i = 4'b1110;
      tick();
      chk("nonowner_sttx", {31'd0, bus.sttx_o}, 32'd0);
      chk("nonowner_data", {24'd0, bus.data_o}, 32'h65);
      bus.start_i = 4'b0000;
      tick();
      chk("nonowner_sttx2", {31'd0, bus.sttx_o}, 32'd0);
      bus.start_i = 4'b0001;
      tick();
      chk("own_sttx", {31'd0, bus.sttx_o}, 32'd1);
      chk("own_data", {24'd0, bus.data_o}, 32'h11);
      bus.data_i = 32'h0000_0022;
      tick();
      chk("busy_start_sttx", {31'd0, bus.sttx_o}, 32'd0);
      chk("busy_start_data", {24'd0, bus.data_o}, 32'h11);
      bus.start_i = 4'b0000;
      tick();
      chk("busy_start_sttx2", {31'd0, bus.sttx_o}, 32'd0);
      bus.eot_i = 1'b1;
      tick();
      chk("busy_eot", {28'd0, bus.eot_o}, 32'h1);
      tick();
      chk("grant_eot_ignored", {28'd0, bus.eot_o}, 32'h0);
      bus.eot_i = 1'b0;

      // Reset while a byte is in flight, then a late eot_i.
      bus.data_i = 32'h0000_0033;
      bus.start_i = 4'b0001;
      tick();
      bus.start_i = 4'b0000;
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_gnt", {28'd0, bus.gnt_o}, 32'h0);
      chk("midrst_eot", {28'd0, bus.eot_o}, 32'h0);
      chk("midrst_sttx", {31'd0, bus.sttx_o}, 32'd0);
      chk("midrst_data", {24'd0, bus.data_o}, 32'h0);
      rst = 1'b0;
      bus.req_i = 4'b1111;
      bus.eot_i = 1'b1;
      tick();
      chk("postrst_gnt0", {28'd0, bus.gnt_o}, 32'h1);
      chk("postrst_no_eot", {28'd0, bus.eot_o}, 32'h0);
      bus.eot_i = 1'b0;

      // Timeout instance: first requester found from 0 is 2.
      bus_t.req_i = 4'b0100;
      tick();
      chk("tmo_gnt", {28'd0, bus_t.gnt_o}, 32'h4);
      bus_t.data_i = 32'h005A_0000;
      bus_t.start_i = 4'b0100;
      tick();
      chk("tmo_sttx", {31'd0, bus_t.sttx_o}, 32'd1);
      bus_t.start_i = 4'b0000;
      repeat (7) tick();
      chk("tmo_err_early", {31'd0, bus_t.err_o}, 32'd0);
      chk("tmo_eot_early", {28'd0, bus_t.eot_o}, 32'h0);
      tick();
      chk("tmo_err", {31'd0, bus_t.err_o}, 32'd1);
      chk("tmo_eot", {28'd0, bus_t.eot_o}, 32'h4);
      tick();
      chk("tmo_err_one_cycle", {31'd0, bus_t.err_o}, 32'd0);
      chk("tmo_eot_one_cycle", {28'd0, bus_t.eot_o}, 32'h0);
      bus_t.data_i = 32'h00C3_0000;
      bus_t.start_i = 4'b0100;
      tick();
      bus_t.start_i = 4'b0000;
      repeat (7) tick();
      bus_t.eot_i = 1'b1;
      tick();
      chk("tmo_edge_eot", {28'd0, bus_t.eot_o}, 32'h4);
      chk("tmo_edge_err", {31'd0, bus_t.err_o}, 32'd0);
      chk("tmo_edge_data", {24'd0, bus_t.data_o}, 32'hC3);
      bus_t.eot_i = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Parameters
REQ-001 SHALL provide TMO_CYCLES, default 16'd50000: the maximum number of cycles it waits for eot_i after a byte start before aborting.

Interface
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port req_i, input, 4, per-requester request to own the transmitter; it stays high for the whole multi-byte message.
REQ-005 SHALL have port start_i, input, 4, per-requester one-cycle pulse to send the byte currently on its data lane.
REQ-006 SHALL have port data_i, input, 32, four byte lanes; requester n uses bits [8n+7:8n].
REQ-007 SHALL have port gnt_o, output, 4, one-hot grant, registered.
REQ-008 SHALL have port eot_o, output, 4, per-requester one-cycle end-of-byte pulse, registered.
REQ-009 SHALL have port err_o, output, 1, one-cycle timeout pulse, registered.
REQ-010 SHALL have port sttx_o, output, 1, one-cycle start pulse to the UART transmitter, registered.
REQ-011 SHALL have port data_o, output, 8, byte to the UART transmitter, registered.
REQ-012 SHALL have port eot_i, input, 1, end-of-transmission pulse from the UART transmitter.

Function
REQ-013 SHALL implement a three-state FSM:
- IDLE: no owner.
- GRANT: owner holds the transmitter, no byte in flight.
- BUSY: byte in flight.
REQ-014 SHALL, in IDLE with any req_i bit high at an edge, select the owner round-robin, searching from (last_owner+1) mod 4 upward, and enter GRANT with gnt_o one-hot from the next cycle.
REQ-015 SHALL update last_owner when a grant is issued; at most one gnt_o bit SHALL be high in any cycle.
REQ-016 SHALL, in GRANT, when start_i[owner] is high, latch data lane [owner] into data_o, drive sttx_o=1 for exactly the next cycle, and enter BUSY.
REQ-017 SHALL, in GRANT, when start_i[owner] is low and req_i[owner] is low, clear gnt_o and return to IDLE; a new grant is possible no earlier than the following edge.
REQ-018 SHALL, in GRANT, give start_i[owner] priority over release when both occur in the same cycle; the byte is sent and release is re-evaluated after its eot.
REQ-019 SHALL ignore start_i bits of non-owners in all states, and ignore start_i[owner] while in BUSY.
REQ-020 SHALL hold data_o stable from the sttx_o cycle until the next accepted start; data_o SHALL NOT change on grant changes.
REQ-021 SHALL, in BUSY, ignore eot_i during the sttx_o cycle itself.
REQ-022 SHALL, in BUSY, on eot_i in any later cycle, pulse eot_o[owner] for one cycle and return to GRANT.
REQ-023 SHALL, in BUSY, ignore a req_i[owner] drop; the grant is kept until eot_i or timeout.
REQ-024 SHALL run a BUSY cycle counter cleared on BUSY entry.
REQ-025 SHALL, when the counter reaches TMO_CYCLES with no eot_i, pulse err_o and eot_o[owner] together for one cycle and return to GRANT.
REQ-026 SHALL treat eot_i arriving on the timeout cycle as a normal completion, with err_o=0.
REQ-027 SHALL ignore eot_i in IDLE and GRANT.
REQ-028 SHALL make sttx_o, eot_o and err_o zero in every cycle other than those specified.

Reset
REQ-029 SHALL, on rst_i high at an edge, set the state to IDLE, gnt_o=0, eot_o=0, err_o=0, sttx_o=0, data_o=8'h00, counter=0, and last_owner=3, so requester 0 wins first.
REQ-030 SHALL give rst_i priority over all other inputs, abandon any byte in flight mid-operation without pulsing eot_o, and ignore eot_i arriving after reset.

Verification
REQ-031 SHALL cover single owner: req_i=0001, start_i[0] pulse with lane0=8'h79, eot_i 10 cycles later -> gnt_o=0001, one sttx_o pulse, data_o=8'h79, one eot_o=0001 pulse, state back to GRANT.
REQ-032 SHALL cover round-robin: req_i=1111 held, each owner sends one byte then drops req -> grant order 0,1,2,3,0.
REQ-033 SHALL cover a 4-byte message: owner 2 sends 8'h79, 8'h6F, 8'h79, 8'h65 while req_i=0101 -> gnt_o stays 0100 for the whole message, requester 0 gets granted only after req_i[2] drops.
REQ-034 SHALL cover ignored inputs: non-owner start_i pulses in GRANT, and owner start_i pulses in BUSY -> no sttx_o, data_o unchanged.
REQ-035 SHALL cover timeout: TMO_CYCLES=8, no eot_i -> err_o and eot_o[owner] pulse on the 8th BUSY cycle; eot_i on exactly that cycle -> err_o=0.
REQ-036 SHALL cover reset mid-operation: rst_i asserted in BUSY, then eot_i -> all outputs at reset values, no eot_o pulse, next grant goes to requester 0.
